// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: rebuilds pixel coordinates and colour from VGA sync edges,
// tracks lock against the expected timing, counts violations, signs each frame.
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in_i,
  output logic        pix_valid_o,
  output logic [9:0]  pix_x_o,
  output logic [9:0]  pix_y_o,
  output logic [5:0]  pix_rgb_o,
  output logic        frame_done_o,
  output logic [15:0] frame_sig_o,
  output logic        locked_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_SEED  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  V_SEED  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  X_END   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_END   = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    HSYNCED = 2'd1,
    VSYNCED = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  function automatic logic [15:0] rotl1(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  // A horizontal violation outranks everything and decides between HSYNCED and SEARCH.
  function automatic state_e next_state(input state_e cur, input logic hedge,
                                        input logic vedge, input logic h_viol,
                                        input logic v_viol, input logic v_at);
    state_e nxt;
    nxt = cur;
    case (cur)
      SEARCH: begin
        if (hedge) nxt = HSYNCED;
        else       nxt = SEARCH;
      end
      HSYNCED: begin
        if (h_viol)     nxt = hedge ? HSYNCED : SEARCH;
        else if (vedge) nxt = VSYNCED;
        else            nxt = HSYNCED;
      end
      VSYNCED: begin
        if (h_viol)              nxt = hedge ? HSYNCED : SEARCH;
        else if (vedge && v_at)  nxt = LOCKED;
        else if (v_viol)         nxt = HSYNCED;
        else                     nxt = VSYNCED;
      end
      LOCKED: begin
        if (h_viol)      nxt = hedge ? HSYNCED : SEARCH;
        else if (v_viol) nxt = HSYNCED;
        else             nxt = LOCKED;
      end
      default: nxt = SEARCH;
    endcase
    return nxt;
  endfunction

  logic [7:0]  s_q;
  logic        hs_prev_q, vs_prev_q;
  logic [9:0]  px_q, py_q;
  state_e      state_q, state_d;
  logic        locked_q;
  logic        valid_q, done_q;
  logic [9:0]  x_q, y_q;
  logic [5:0]  rgb_q;
  logic [15:0] acc_q, acc_d, sig_q;
  logic [7:0]  err_q, err_d;

  logic        hedge_s, vedge_s, h_viol_s, v_viol_s, v_at_s, viol_s;
  logic [9:0]  px_inc_s, py_inc_s, px_d, py_d;
  logic [5:0]  rgb_s;
  logic        valid_d, done_d;

  // Coordinate prediction for the sample in S, violation detection and signature update.
  always_comb begin
    hedge_s  = ~s_q[7] & hs_prev_q;
    vedge_s  = ~s_q[3] & vs_prev_q;
    px_inc_s = (px_q == H_LAST) ? 10'd0 : px_q + 10'd1;
    px_d     = hedge_s ? H_SEED : px_inc_s;
    if (px_d == 10'd0) begin
      py_inc_s = (py_q == V_LAST) ? 10'd0 : py_q + 10'd1;
    end else begin
      py_inc_s = py_q;
    end
    py_d     = vedge_s ? V_SEED : py_inc_s;
    h_viol_s = hedge_s ? (px_inc_s != H_SEED) : (px_inc_s == H_SEED);
    v_at_s   = (px_d == 10'd0) && (py_inc_s == V_SEED);
    v_viol_s = vedge_s ? ~v_at_s : v_at_s;
    viol_s   = (h_viol_s && (state_q != SEARCH)) ||
               (v_viol_s && ((state_q == VSYNCED) || (state_q == LOCKED)));
    state_d  = next_state(state_q, hedge_s, vedge_s, h_viol_s, v_viol_s, v_at_s);
    rgb_s    = {s_q[0], s_q[4], s_q[1], s_q[5], s_q[2], s_q[6]};
    valid_d  = (state_d == LOCKED) && (px_d < H_ACT) && (py_d < V_ACT);
    done_d   = valid_d && (px_d == X_END) && (py_d == Y_END);
    if (valid_d) begin
      if ((px_d == 10'd0) && (py_d == 10'd0)) begin
        acc_d = {10'd0, rgb_s};
      end else begin
        acc_d = rotl1(acc_q) + {10'd0, rgb_s};
      end
    end else begin
      acc_d = acc_q;
    end
    if (viol_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // Lock FSM; locked follows the state being entered so it lines up with the O stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  // Input register with sync history held high across reset, counters and O stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 8'h88;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      px_q      <= 10'd0;
      py_q      <= 10'd0;
      valid_q   <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      rgb_q     <= 6'd0;
      done_q    <= 1'b0;
      acc_q     <= 16'd0;
      sig_q     <= 16'd0;
      err_q     <= 8'd0;
    end else begin
      s_q       <= vga_in_i;
      hs_prev_q <= s_q[7];
      vs_prev_q <= s_q[3];
      px_q      <= px_d;
      py_q      <= py_d;
      valid_q   <= valid_d;
      x_q       <= px_d;
      y_q       <= py_d;
      rgb_q     <= rgb_s;
      done_q    <= done_d;
      acc_q     <= acc_d;
      sig_q     <= done_d ? acc_d : sig_q;
      err_q     <= err_d;
    end
  end

  assign pix_valid_o  = valid_q;
  assign pix_x_o      = x_q;
  assign pix_y_o      = y_q;
  assign pix_rgb_o    = rgb_q;
  assign frame_done_o = done_q;
  assign frame_sig_o  = sig_q;
  assign locked_o     = locked_q;
  assign err_count_o  = err_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: drives a reduced-size VGA raster (16x8 active, 25x15 total)
// and checks lock, signatures, error counting and reset against hand-derived values.
module tb_vga_rx_monitor;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  vga_in = 8'h88;
  logic        pix_valid, frame_done, locked;
  logic [9:0]  pix_x, pix_y;
  logic [5:0]  pix_rgb;
  logic [15:0] frame_sig;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_in_i(vga_in),
    .pix_valid_o(pix_valid), .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_rgb_o(pix_rgb),
    .frame_done_o(frame_done), .frame_sig_o(frame_sig), .locked_o(locked),
    .err_count_o(err_count)
  );

  // generator and monitor state
  int gx = 0, gy = 0, cyc = 0;
  int pat_x = -1, pat_y = -1;
  logic [5:0] pat_c = 6'd0;
  bit short_line = 1'b0, no_vsync = 1'b0;
  int done_cnt = 0, valid_cnt = 0, bad_valid = 0;
  logic [15:0] cap_sig = 16'd0;
  int cap_x = 0, cap_y = 0, cap_rgb = 0;
  bit prev_locked = 1'b0, prev_vs = 1'b1;
  int lock_rise_cyc = -1, vfall_cyc = -1;

  typedef struct {
    int         x;
    int         y;
    logic [5:0] c;
    logic [15:0] sig;
    logic [5:0] end_rgb;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] pack(input bit hs, input bit vs, input logic [5:0] c);
    // c = {R1,R0,G1,G0,B1,B0}; bus = {hs,B0,G0,R0,vs,B1,G1,R1}
    return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
  endfunction

  task automatic observe();
    if (frame_done) begin
      done_cnt++;
      cap_sig = frame_sig;
      cap_x   = pix_x;
      cap_y   = pix_y;
      cap_rgb = pix_rgb;
    end
    if (pix_valid) valid_cnt++;
    if (pix_valid && !locked) bad_valid++;
    if (locked && !prev_locked) lock_rise_cyc = cyc;
    prev_locked = locked;
  endtask

  task automatic drive_raw(input logic [7:0] v);
    vga_in = v;
    if (!v[3] && prev_vs) vfall_cyc = cyc + 1;
    prev_vs = v[3];
    @(posedge clk);
    cyc++;
    #1;
    observe();
  endtask

  task automatic gen_tick();
    bit hs, vs;
    logic [5:0] c;
    hs = !((gx >= HA + HF) && (gx < HA + HF + HS));
    vs = no_vsync || !((gy >= VA + VF) && (gy < VA + VF + VS));
    c  = ((gx == pat_x) && (gy == pat_y)) ? pat_c : 6'd0;
    drive_raw(pack(hs, vs, c));
    if ((gx == HT - 1) || (short_line && (gy == 3) && (gx == HT - 2))) begin
      if (gx == HT - 2) short_line = 1'b0;
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  // runs the generator up to the next (0,0); also finishes a partial frame
  task automatic run_frame(input string tag);
    int n;
    n = 0;
    done_cnt  = 0;
    valid_cnt = 0;
    do begin
      gen_tick();
      n++;
    end while (!((gx == 0) && (gy == 0)) && (n < 2 * HT * VT));
    check({tag, "_frame_bound"}, int'(n < 2 * HT * VT), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_rgb"}, pix_rgb, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_sig"}, frame_sig, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic check_good_frame(input string tag, input int sig, input int end_rgb, input int err);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_sig"}, cap_sig, sig);
    check({tag, "_done_x"}, cap_x, HA - 1);
    check({tag, "_done_y"}, cap_y, VA - 1);
    check({tag, "_done_rgb"}, cap_rgb, end_rgb);
    check({tag, "_valid_cnt"}, valid_cnt, HA * VA);
    check({tag, "_err"}, err_count, err);
  endtask

  initial begin
    // 128 active pixels: rotation count from pixel k to the end is 127-k (mod 16)
    vecs[0] = '{-1, -1, 6'h00, 16'h0000, 6'h00};
    vecs[1] = '{15,  7, 6'h3F, 16'h003F, 6'h3F};
    vecs[2] = '{ 0,  0, 6'h3F, 16'h801F, 6'h00};
    vecs[3] = '{ 1,  0, 6'h01, 16'h4000, 6'h00};
    vecs[4] = '{ 0,  7, 6'h01, 16'h8000, 6'h00};
    vecs[5] = '{15,  7, 6'h15, 16'h0015, 6'h15};
    vecs[6] = '{14,  7, 6'h01, 16'h0002, 6'h00};

    rst_n  = 1'b0;
    vga_in = 8'h88;
    repeat (3) @(posedge clk);
    #1;
    check_zero("por");
    rst_n = 1'b1;

    // acquisition: first hsync fall, then two vsync falls
    run_frame("acq0");
    check("acq0_locked", locked, 0);
    run_frame("acq1");
    check("acq1_locked", locked, 1);
    check("acq1_lock_latency", lock_rise_cyc - vfall_cyc, 1);
    check("acq1_err", err_count, 0);
    check("acq1_no_done", done_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      pat_x = vecs[i].x;
      pat_y = vecs[i].y;
      pat_c = vecs[i].c;
      run_frame($sformatf("vec%0d", i));
      check_good_frame($sformatf("vec%0d", i), vecs[i].sig, vecs[i].end_rgb, 0);
      check($sformatf("vec%0d_locked", i), locked, 1);
    end
    pat_x = -1;
    pat_y = -1;

    // one 24-clock line while locked
    bad_valid  = 0;
    short_line = 1'b1;
    run_frame("short");
    check("short_err", err_count, 1);
    check("short_locked", locked, 0);
    check("short_done", done_cnt, 0);
    run_frame("short_relock");
    check("short_relock_locked", locked, 1);
    check("short_relock_err", err_count, 1);
    run_frame("short_after");
    check_good_frame("short_after", 16'h0000, 0, 1);
    check("short_no_valid_unlocked", bad_valid, 0);

    // one suppressed vsync pulse
    no_vsync = 1'b1;
    run_frame("nov");
    no_vsync = 1'b0;
    check("nov_err", err_count, 2);
    check("nov_locked", locked, 0);
    check("nov_done_before_miss", done_cnt, 1);
    run_frame("nov_vsynced");
    check("nov_vsynced_locked", locked, 0);
    check("nov_vsynced_err", err_count, 2);
    run_frame("nov_relock");
    check("nov_relock_locked", locked, 1);
    check("nov_relock_err", err_count, 2);

    // asynchronous reset in the middle of line 2 of a locked frame
    repeat (2 * HT + 5) gen_tick();
    check("rst_pre_valid", pix_valid, 1);
    check("rst_pre_err", err_count, 2);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    gen_tick();
    gen_tick();
    rst_n = 1'b1;
    run_frame("rst_acq0");
    check("rst_acq0_locked", locked, 0);
    run_frame("rst_acq1");
    check("rst_acq1_locked", locked, 1);
    check("rst_acq1_lock_latency", lock_rise_cyc - vfall_cyc, 1);
    run_frame("rst_after");
    check_good_frame("rst_after", 16'h0000, 0, 0);

    // saturation: hsync falls every 4 clocks, each after the first is misplaced
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 301; i++) begin
      drive_raw(8'h08);
      drive_raw(8'h08);
      drive_raw(8'h88);
      drive_raw(8'h88);
      if (i == 10)  check("sat_count_10", err_count, 10);
      if (i == 255) check("sat_count_255", err_count, 255);
    end
    check("sat_final", err_count, 255);
    check("sat_locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
